fixed3_norm_inv_sched: RTL and testbench

Shares one `Fixed3_NormV2` → `Fixed3_Inv_V3` chain among `NUM_REQ` requesters, such as ray generators and shadow/light-direction setup. It arbitrates requests round-robin and issues one strobe per cycle into the chain. Each dispatch is tagged with its requester ID in an in-order tag FIFO, and the inverse-direction result is routed back to the owning requester. It sits between the ray-setup clients and the shared normalize/inverse datapath, which has no backpressure.

---
 rtl/fixed3_norm_inv_sched_pkg.sv | 31 +++
 rtl/fixed3_norm_inv_sched_if.sv | 35 +++
 rtl/fixed3_norm_inv_sched_tag_fifo.sv | 61 ++++++
 rtl/fixed3_norm_inv_sched.sv | 119 +++++++++++
 tb/tb_fixed3_norm_inv_sched.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fixed3_norm_inv_sched_pkg.sv
// Shared Fixed3 vector type and scheduler sizing constants.
package fixed3_norm_inv_sched_pkg;

   localparam int unsigned FIXED3_W = 32;

   // Three signed Q16.16 components.
   typedef struct packed {
      logic signed [FIXED3_W-1:0] x;
      logic signed [FIXED3_W-1:0] y;
      logic signed [FIXED3_W-1:0] z;
   } Fixed3;

   function automatic Fixed3 _Fixed3(input logic signed [FIXED3_W-1:0] x,
                                     input logic signed [FIXED3_W-1:0] y,
                                     input logic signed [FIXED3_W-1:0] z);
      Fixed3 r;
      r.x = x;
      r.y = y;
      r.z = z;
      return r;
   endfunction

   // Tag width needed to name one of n requesters (at least one bit).
   function automatic int unsigned sched_tag_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned SCHED_NUM_REQ = 4;
   localparam int unsigned SCHED_TAG_W   = sched_tag_w(SCHED_NUM_REQ);

endpackage

// File: rtl/fixed3_norm_inv_sched_if.sv
// Requester / datapath-chain bundle for the normalize-inverse scheduler.
interface fixed3_norm_inv_sched_if
   import fixed3_norm_inv_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ      = SCHED_NUM_REQ,
   parameter int unsigned MAX_INFLIGHT = 8
) ();

   localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

   logic [NUM_REQ-1:0]        req_valid;
   Fixed3 [NUM_REQ-1:0]       req_v;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      norm_strobe;
   Fixed3                     norm_v;
   logic                      inv_valid;
   Fixed3                     inv_ov;
   logic [NUM_REQ-1:0]        rsp_valid;
   Fixed3                     rsp_ov;
   logic [CNT_W-1:0]          inflight;
   logic                      err_orphan;

   // Scheduler side.
   modport slave (
      input  req_valid, req_v, inv_valid, inv_ov,
      output req_ready, norm_strobe, norm_v, rsp_valid, rsp_ov, inflight, err_orphan
   );

   // Requesters plus datapath chain side.
   modport master (
      output req_valid, req_v, inv_valid, inv_ov,
      input  req_ready, norm_strobe, norm_v, rsp_valid, rsp_ov, inflight, err_orphan
   );

endinterface

// File: rtl/fixed3_norm_inv_sched_tag_fifo.sv
// In-order tag FIFO; push+pop in the same cycle is allowed when non-empty.
module fixed3_norm_inv_sched_tag_fifo #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign dout_o  = mem_q[rd_ptr_q];

   // Qualify push/pop and compute next pointers/count (pointers wrap on power-of-two depth).
   always_comb begin
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: ;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/fixed3_norm_inv_sched.sv
// Round-robin scheduler sharing one Fixed3 normalize -> inverse chain among requesters.
module fixed3_norm_inv_sched
   import fixed3_norm_inv_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ      = SCHED_NUM_REQ,
   parameter int unsigned MAX_INFLIGHT = 8
) (
   input logic                    clk,
   input logic                    resetn,
   fixed3_norm_inv_sched_if.slave bus
);

   localparam int unsigned       TAG_W    = sched_tag_w(NUM_REQ);
   localparam int unsigned       CNT_W    = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_INFLIGHT);
   localparam logic [TAG_W-1:0]  LAST_IDX = TAG_W'(NUM_REQ - 1);

   logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               norm_strobe_q, norm_strobe_d;
   Fixed3              norm_v_q, norm_v_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   Fixed3              rsp_ov_q, rsp_ov_d;
   logic [CNT_W-1:0]   inflight_q, inflight_d;
   logic               err_orphan_q, err_orphan_d;

   logic               grant;
   logic [TAG_W-1:0]   grant_idx;
   logic [TAG_W-1:0]   cand;
   logic               tag_full, tag_empty, tag_pop;
   logic [TAG_W-1:0]   tag_head;

   assign tag_pop = bus.inv_valid && !tag_empty;

   // Round-robin pick starting at rr_ptr; gated off while the registered count is at the limit.
   // The FIFO full flag mirrors that limit and is folded in so the two can never disagree.
   always_comb begin
      grant     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = TAG_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant && bus.req_valid[cand]) begin
            grant     = 1'b1;
            grant_idx = cand;
         end
      end
      if ((inflight_q >= CNT_MAX) || tag_full) grant = 1'b0;
   end

   assign bus.req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;

   // Next-state for dispatch, return routing, occupancy and the sticky orphan flag.
   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      norm_strobe_d = grant;
      norm_v_d      = norm_v_q;
      rsp_valid_d   = '0;
      rsp_ov_d      = rsp_ov_q;
      inflight_d    = inflight_q;
      err_orphan_d  = err_orphan_q;
      if (grant) begin
         rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
         norm_v_d = bus.req_v[grant_idx];
      end
      if (tag_pop) begin
         rsp_valid_d = NUM_REQ'(1) << tag_head;
         rsp_ov_d    = bus.inv_ov;
      end
      if (bus.inv_valid && tag_empty) err_orphan_d = 1'b1;
      case ({grant, tag_pop})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: ;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr_q      <= '0;
         norm_strobe_q <= 1'b0;
         norm_v_q      <= '0;
         rsp_valid_q   <= '0;
         rsp_ov_q      <= '0;
         inflight_q    <= '0;
         err_orphan_q  <= 1'b0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         norm_strobe_q <= norm_strobe_d;
         norm_v_q      <= norm_v_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_ov_q      <= rsp_ov_d;
         inflight_q    <= inflight_d;
         err_orphan_q  <= err_orphan_d;
      end
   end

   assign bus.norm_strobe = norm_strobe_q;
   assign bus.norm_v      = norm_v_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_ov      = rsp_ov_q;
   assign bus.inflight    = inflight_q;
   assign bus.err_orphan  = err_orphan_q;

   fixed3_norm_inv_sched_tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (grant),
      .din_i   (grant_idx),
      .pop_i   (tag_pop),
      .dout_o  (tag_head),
      .full_o  (tag_full),
      .empty_o (tag_empty)
   );

endmodule

// File: tb/tb_fixed3_norm_inv_sched.sv
// Bench for fixed3_norm_inv_sched: stub chain with variable latency, queue-based reference model.
module tb_fixed3_norm_inv_sched;
   import fixed3_norm_inv_sched_pkg::*;

   localparam int unsigned NR   = SCHED_NUM_REQ;
   localparam int unsigned MAXF = 8;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   fixed3_norm_inv_sched_if #(.NUM_REQ(NR), .MAX_INFLIGHT(MAXF)) bus ();

   fixed3_norm_inv_sched #(.NUM_REQ(NR), .MAX_INFLIGHT(MAXF)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Stand-in for the normalize/inverse chain: any fixed bijective transform.
   function automatic Fixed3 chain_fn(input Fixed3 v);
      Fixed3 r;
      r.x = ~v.x;
      r.y = v.y + 32'sh0001_0000;
      r.z = v.z ^ 32'sh5A5A_5A5A;
      return r;
   endfunction

   // ---------------- stub chain (shares resetn) ----------------
   int unsigned chain_lat = 20;
   logic        man_inv   = 1'b0;
   logic [31:0] st_vld;
   Fixed3       st_v [32];

   always @(posedge clk or negedge resetn) begin
      if (!resetn) st_vld <= '0;
      else         st_vld <= {st_vld[30:0], bus.norm_strobe};
   end
   always @(posedge clk) begin
      st_v[0] <= bus.norm_v;
      for (int i = 1; i < 32; i++) st_v[i] <= st_v[i-1];
   end
   assign bus.inv_valid = st_vld[chain_lat-1] | man_inv;
   assign bus.inv_ov    = man_inv ? _Fixed3(32'sh7777, 0, 0) : chain_fn(st_v[chain_lat-1]);

   // ---------------- reference model ----------------
   typedef struct {
      logic [SCHED_TAG_W-1:0] owner;
      Fixed3                  v;
   } ent_t;

   ent_t         mq[$];
   ent_t         me;
   int           m_rr, m_infl, mg;
   logic         m_strobe, m_orphan;
   Fixed3        m_normv, m_rspov;
   logic [NR-1:0] m_rsp, mexp;

   always @(negedge clk) begin
      if (!resetn) begin
         mq.delete();
         m_rr = 0; m_infl = 0; m_strobe = 0; m_orphan = 0;
         m_normv = '0; m_rspov = '0; m_rsp = '0;
         chk("rst_strobe", 96'(bus.norm_strobe), 96'(0));
         chk("rst_infl",   96'(bus.inflight),    96'(0));
         chk("rst_rsp",    96'(bus.rsp_valid),   96'(0));
         chk("rst_orphan", 96'(bus.err_orphan),  96'(0));
      end else begin
         mg = -1;
         if (m_infl < int'(MAXF))
            for (int k = 0; k < int'(NR); k++)
               if (mg < 0 && bus.req_valid[(m_rr + k) % NR]) mg = (m_rr + k) % NR;
         mexp = '0;
         if (mg >= 0) mexp[mg] = 1'b1;
         chk("m_ready",  96'(bus.req_ready),   96'(mexp));
         chk("m_strobe", 96'(bus.norm_strobe), 96'(m_strobe));
         chk("m_normv",  bus.norm_v,           m_normv);
         chk("m_rsp",    96'(bus.rsp_valid),   96'(m_rsp));
         chk("m_rspov",  bus.rsp_ov,           m_rspov);
         chk("m_infl",   96'(bus.inflight),    96'(m_infl));
         chk("m_orphan", 96'(bus.err_orphan),  96'(m_orphan));
         // advance: pop uses the queue as it was before this cycle's push
         m_rsp = '0;
         if (bus.inv_valid) begin
            if (mq.size() > 0) begin
               me      = mq.pop_front();
               m_rsp   = NR'(1) << me.owner;
               m_rspov = chain_fn(me.v);
               m_infl--;
            end else begin
               m_orphan = 1'b1;
            end
         end
         if (mg >= 0) begin
            m_strobe = 1'b1;
            m_normv  = bus.req_v[mg];
            mq.push_back(ent_t'{owner: SCHED_TAG_W'(mg), v: bus.req_v[mg]});
            m_rr     = (mg + 1) % NR;
            m_infl++;
         end else begin
            m_strobe = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [NR-1:0] valid;
      logic [NR-1:0] ready;
   } vec_t;
   vec_t tbl [8];

   task automatic rand_vecs();
      for (int i = 0; i < int'(NR); i++) bus.req_v[i] = _Fixed3($urandom, $urandom, $urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int            n_str, n_g;
   logic          seen_ret, regrant_chk;
   logic [NR-1:0] got_rsp;
   Fixed3         got_ov, vec1;

   initial begin
      bus.req_valid = '0;
      bus.req_v     = '0;
      resetn        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_normv", bus.norm_v,          96'(0));
      chk("reset_rspov", bus.rsp_ov,          96'(0));
      chk("reset_ready", 96'(bus.req_ready),  96'(0));
      resetn = 1'b1;

      // Arbitration table from reset (rr starts at 0), chain slow enough that nothing returns.
      tbl[0] = '{valid: 4'b0000, ready: 4'b0000};
      tbl[1] = '{valid: 4'b0100, ready: 4'b0100};
      tbl[2] = '{valid: 4'b0110, ready: 4'b0010};
      tbl[3] = '{valid: 4'b1111, ready: 4'b0100};
      tbl[4] = '{valid: 4'b1111, ready: 4'b1000};
      tbl[5] = '{valid: 4'b0001, ready: 4'b0001};
      tbl[6] = '{valid: 4'b0001, ready: 4'b0001};
      tbl[7] = '{valid: 4'b1001, ready: 4'b1000};
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         bus.req_valid = tbl[i].valid;
         rand_vecs();
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), 96'(bus.req_ready), 96'(tbl[i].ready));
      end
      @(posedge clk); #1 bus.req_valid = '0;
      idle(40);

      // Single request from requester 2.
      chain_lat = 4;
      @(posedge clk); #1;
      vec1 = _Fixed3(0, 32'sh0001_0000, 32'sh0001_0000);
      bus.req_v[2]  = vec1;
      bus.req_valid = 4'b0100;
      @(posedge clk); #1 bus.req_valid = '0;
      n_str = 0; got_rsp = '0; got_ov = '0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.norm_strobe) n_str++;
         if (bus.rsp_valid != '0 && got_rsp == '0) begin
            got_rsp = bus.rsp_valid;
            got_ov  = bus.rsp_ov;
         end
      end
      chk("single_strobes",  96'(n_str),        96'(1));
      chk("single_rsp",      96'(got_rsp),      96'(4'b0100));
      chk("single_ov",       got_ov,            chain_fn(vec1));
      chk("single_inflight", 96'(bus.inflight), 96'(0));
      idle(2);

      // Full stall with a 20-cycle chain.
      chain_lat = 20;
      @(posedge clk); #1 bus.req_valid = '1;
      n_g = 0; seen_ret = 1'b0; regrant_chk = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (regrant_chk) begin
            chk("full_regrant", 96'(bus.req_ready != '0), 96'(1));
            regrant_chk = 1'b0;
         end
         if (bus.inv_valid && !seen_ret) begin
            seen_ret    = 1'b1;
            regrant_chk = 1'b1;
         end
         if (!seen_ret && bus.req_ready != '0) n_g++;
      end
      chk("full_grants", 96'(n_g), 96'(8));
      @(posedge clk); #1 bus.req_valid = '0;
      idle(40);

      // Random traffic with a short chain: steady grant+return overlap.
      chain_lat = 6;
      for (int c = 0; c < 150; c++) begin
         @(posedge clk); #1;
         bus.req_valid = NR'($urandom_range(0, 15));
         rand_vecs();
      end
      @(posedge clk); #1 bus.req_valid = '0;
      idle(30);
      chk("rand_drained", 96'(bus.inflight), 96'(0));

      // Orphan return.
      @(posedge clk); #1 man_inv = 1'b1;
      @(posedge clk); #1 man_inv = 1'b0;
      @(negedge clk);
      chk("orphan_flag", 96'(bus.err_orphan), 96'(1));
      chk("orphan_rsp",  96'(bus.rsp_valid),  96'(0));
      chk("orphan_infl", 96'(bus.inflight),   96'(0));
      repeat (5) @(negedge clk);
      chk("orphan_sticky", 96'(bus.err_orphan), 96'(1));

      // Mid-stream reset with 5 in flight.
      chain_lat = 20;
      @(posedge clk); #1 bus.req_valid = '1;
      repeat (5) @(posedge clk);
      #1 bus.req_valid = '0;
      @(negedge clk);
      chk("mid_inflight", 96'(bus.inflight), 96'(5));
      #1 resetn = 1'b0;
      #1;
      chk("mid_strobe", 96'(bus.norm_strobe), 96'(0));
      chk("mid_normv",  bus.norm_v,           96'(0));
      chk("mid_rsp",    96'(bus.rsp_valid),   96'(0));
      chk("mid_rspov",  bus.rsp_ov,           96'(0));
      chk("mid_infl",   96'(bus.inflight),    96'(0));
      chk("mid_orphan", 96'(bus.err_orphan),  96'(0));
      repeat (2) @(posedge clk);
      #1;
      resetn        = 1'b1;
      bus.req_valid = '1;
      @(negedge clk);
      chk("mid_rr_restart", 96'(bus.req_ready), 96'(4'b0001));
      @(posedge clk); #1 bus.req_valid = '0;
      idle(40);
      chk("final_infl", 96'(bus.inflight), 96'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got no end of test, expected end before %0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
